// File: rtl/matrix_pkg.sv
// Shared types and constants for the 5x7 status LED matrix (scanner and image decoder).
package matrix_pkg;

  localparam int unsigned MATRIX_COLUMNS = 5;
  localparam int unsigned MATRIX_ROWS    = 7;
  localparam int unsigned COL_IDX_W      = 3;

  localparam logic [MATRIX_ROWS-1:0] ROWS_OFF = 7'h7F;
  localparam logic [COL_IDX_W-1:0]   LAST_COL = 3'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    BLANK = 2'd2,
    DRIVE = 2'd3
  } matrix_state_e;

  // Active-high one-hot column select for a column index.
  function automatic logic [MATRIX_COLUMNS-1:0] col_onehot(input logic [COL_IDX_W-1:0] idx);
    return MATRIX_COLUMNS'(1) << idx;
  endfunction

endpackage

// File: rtl/matrix_dwell_timer.sv
// Loadable down-counter timing the BLANK and DRIVE dwells; done_c is high while the count is zero.
module matrix_dwell_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done_c
);

  logic [W-1:0] count_q, count_d;

  // Stops at zero rather than wrapping; the FSM reloads on every state entry.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done_c = (count_q == '0);

endmodule

// File: rtl/matrix_column_scanner.sv
// Time-multiplexed column scanner for the 5x7 LED matrix with per-frame image snapshot.
// Optional blinking of the displayed image is built when MATRIX_BLINK_EN is defined.
module matrix_column_scanner
  import matrix_pkg::*;
#(
  parameter int unsigned CLK_DIV      = 5000,
  parameter int unsigned BLANK_CYCLES = 50,
  parameter int unsigned BLINK_FRAMES = 25
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [6:0] column_4,
  input  logic [6:0] column_3,
  input  logic [6:0] column_2,
  input  logic [6:0] column_1,
  input  logic [6:0] column_0,
  input  logic       blink,
  output logic [6:0] rows,
  output logic [4:0] columns,
  output logic       frame_start
);

  localparam int unsigned DWELL_MAX = (CLK_DIV > BLANK_CYCLES) ? CLK_DIV : BLANK_CYCLES;
  localparam int unsigned DW        = $clog2(DWELL_MAX + 1);
  localparam bit          HAS_BLANK = (BLANK_CYCLES != 0);

  localparam logic [DW-1:0] DRIVE_LOAD = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] BLANK_LOAD = DW'(HAS_BLANK ? BLANK_CYCLES - 1 : 0);

  matrix_state_e state_q, state_d;
  logic [COL_IDX_W-1:0] col_idx_q, col_idx_d;
  logic [MATRIX_COLUMNS-1:0][MATRIX_ROWS-1:0] shadow_q, shadow_d;
  logic [MATRIX_ROWS-1:0]    rows_q, rows_d;
  logic [MATRIX_COLUMNS-1:0] columns_q, columns_d;
  logic                      frame_start_q, frame_start_d;

  logic          tmr_load;
  logic [DW-1:0] tmr_val;
  logic          tmr_done;
  logic          frame_dark;

  matrix_dwell_timer #(.W(DW)) u_dwell (
    .clock    (clock),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done_c   (tmr_done)
  );

  // Next state, snapshot and registered outputs derived from the current state.
  always_comb begin
    state_d       = state_q;
    col_idx_d     = col_idx_q;
    shadow_d      = shadow_q;
    tmr_load      = 1'b0;
    tmr_val       = '0;
    frame_start_d = (state_q == LOAD);
    columns_d     = '0;
    rows_d        = ROWS_OFF;

    if (state_q == DRIVE) begin
      columns_d = col_onehot(col_idx_q);
      if (!frame_dark) begin
        rows_d = shadow_q[col_idx_q];
      end
    end

    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        shadow_d  = {column_4, column_3, column_2, column_1, column_0};
        col_idx_d = LAST_COL;
        tmr_load  = 1'b1;
        if (HAS_BLANK) begin
          state_d = BLANK;
          tmr_val = BLANK_LOAD;
        end else begin
          state_d = DRIVE;
          tmr_val = DRIVE_LOAD;
        end
      end
      BLANK: begin
        if (tmr_done) begin
          state_d  = DRIVE;
          tmr_load = 1'b1;
          tmr_val  = DRIVE_LOAD;
        end
      end
      DRIVE: begin
        if (tmr_done) begin
          tmr_load = 1'b1;
          if (col_idx_q != '0) begin
            col_idx_d = col_idx_q - COL_IDX_W'(1);
            if (HAS_BLANK) begin
              state_d = BLANK;
              tmr_val = BLANK_LOAD;
            end else begin
              state_d = DRIVE;
              tmr_val = DRIVE_LOAD;
            end
          end else begin
            state_d = enable ? LOAD : IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      col_idx_q     <= LAST_COL;
      shadow_q      <= {MATRIX_COLUMNS{ROWS_OFF}};
      rows_q        <= ROWS_OFF;
      columns_q     <= '0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      col_idx_q     <= col_idx_d;
      shadow_q      <= shadow_d;
      rows_q        <= rows_d;
      columns_q     <= columns_d;
      frame_start_q <= frame_start_d;
    end
  end

`ifdef MATRIX_BLINK_EN
  localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic          phase_on_q, phase_on_d;
  logic          dark_q, dark_d;

  // phase_on_q is the phase for the frame about to be loaded; blink is latched per frame.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    phase_on_d  = phase_on_q;
    dark_d      = dark_q;
    if (state_q == LOAD) begin
      dark_d = blink & ~phase_on_q;
      if (!blink) begin
        frame_cnt_d = '0;
        phase_on_d  = 1'b1;
      end else if (frame_cnt_q == FW'(BLINK_FRAMES - 1)) begin
        frame_cnt_d = '0;
        phase_on_d  = ~phase_on_q;
      end else begin
        frame_cnt_d = frame_cnt_q + FW'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      frame_cnt_q <= '0;
      phase_on_q  <= 1'b1;
      dark_q      <= 1'b0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      phase_on_q  <= phase_on_d;
      dark_q      <= dark_d;
    end
  end

  assign frame_dark = dark_q;
`else
  logic unused_blink;
  assign unused_blink = blink;
  assign frame_dark   = 1'b0;
`endif

  assign rows        = rows_q;
  assign columns     = columns_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_matrix_column_scanner.sv
// Self-checking bench: two scanner configurations against a frame-position reference model.
module tb_matrix_column_scanner;

  localparam int A_DIV = 4, A_BLANK = 2, A_LEN = 1 + 5 * (A_DIV + A_BLANK);
  localparam int B_DIV = 1, B_BLANK = 0, B_LEN = 1 + 5 * (B_DIV + B_BLANK);

  logic       clock;
  logic       reset;
  logic       enable;
  logic       blink;
  logic [6:0] c4, c3, c2, c1, c0;
  logic [6:0] rows_a, rows_b;
  logic [4:0] columns_a, columns_b;
  logic       fs_a, fs_b;

  int n_pass  = 0;
  int n_total = 0;

  // Model state: position within the frame of the cycle just ending (-1 = idle).
  int          pos_a  = -1;
  int          pos_b  = -1;
  logic [34:0] snap_a = '1;
  logic [34:0] snap_b = '1;

  matrix_column_scanner #(.CLK_DIV(A_DIV), .BLANK_CYCLES(A_BLANK), .BLINK_FRAMES(2)) dut_a (
    .clock(clock), .reset(reset), .enable(enable),
    .column_4(c4), .column_3(c3), .column_2(c2), .column_1(c1), .column_0(c0),
    .blink(blink), .rows(rows_a), .columns(columns_a), .frame_start(fs_a)
  );

  matrix_column_scanner #(.CLK_DIV(B_DIV), .BLANK_CYCLES(B_BLANK), .BLINK_FRAMES(2)) dut_b (
    .clock(clock), .reset(reset), .enable(enable),
    .column_4(c4), .column_3(c3), .column_2(c2), .column_1(c1), .column_0(c0),
    .blink(blink), .rows(rows_b), .columns(columns_b), .frame_start(fs_b)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Expected {frame_start, columns, rows} one cycle after a state at frame position pos.
  function automatic logic [12:0] model_out(input int pos, input int blank, input int dwell,
                                            input logic [34:0] snap);
    logic [12:0] r;
    int j, w, n;
    r = {1'b0, 5'b00000, 7'h7F};
    if (pos == 0) begin
      r[12] = 1'b1;
    end else if (pos > 0) begin
      j = (pos - 1) / (blank + dwell);
      w = (pos - 1) % (blank + dwell);
      if (w >= blank) begin
        n = 4 - j;
        r[11:7] = 5'(1) << n;
        r[6:0]  = snap[7*n +: 7];
      end
    end
    return r;
  endfunction

  function automatic int next_pos(input int pos, input int len, input logic en);
    if (pos < 0 || pos == len - 1) return en ? 0 : -1;
    return pos + 1;
  endfunction

  task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s at %0t: observed %h expected %h", tag, $time, obs, exp);
  endtask

  task automatic check_reset_outputs();
    check("rst_rows_a", rows_a, 7'h7F);
    check("rst_cols_a", 7'(columns_a), 7'h00);
    check("rst_fs_a", 7'(fs_a), 7'h00);
    check("rst_rows_b", rows_b, 7'h7F);
    check("rst_cols_b", 7'(columns_b), 7'h00);
    check("rst_fs_b", 7'(fs_b), 7'h00);
  endtask

  // One clock: advance the model with pre-edge inputs, then compare both DUTs.
  task automatic step();
    logic        en_s;
    logic [34:0] in_s;
    logic [12:0] ea, eb;
    en_s = enable;
    in_s = {c4, c3, c2, c1, c0};
    @(posedge clock);
    ea = model_out(pos_a, A_BLANK, A_DIV, snap_a);
    if (pos_a == 0) snap_a = in_s;
    pos_a = next_pos(pos_a, A_LEN, en_s);
    eb = model_out(pos_b, B_BLANK, B_DIV, snap_b);
    if (pos_b == 0) snap_b = in_s;
    pos_b = next_pos(pos_b, B_LEN, en_s);
    #1;
    check("rows_a", rows_a, ea[6:0]);
    check("cols_a", 7'(columns_a), 7'(ea[11:7]));
    check("fs_a", 7'(fs_a), 7'(ea[12]));
    check("rows_b", rows_b, eb[6:0]);
    check("cols_b", 7'(columns_b), 7'(eb[11:7]));
    check("fs_b", 7'(fs_b), 7'(eb[12]));
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic wait_cols(input logic [4:0] tgt, input string tag);
    for (int k = 0; k < 200 && columns_a !== tgt; k++) step();
    if (columns_a !== tgt) begin
      n_total++;
      $error("FAIL wait_%s: columns %b never reached %b", tag, columns_a, tgt);
    end
  endtask

  task automatic measure_period();
    int k;
    for (k = 0; k < 100 && fs_a !== 1'b1; k++) step();
    k = 0;
    do begin
      step();
      k++;
    end while (fs_a !== 1'b1 && k < 100);
    check("period_a", 7'(k), 7'(A_LEN));
  endtask

  initial begin
    reset  = 1'b1;
    enable = 1'b0;
    blink  = 1'b0;
    c4 = 7'h01; c3 = 7'h02; c2 = 7'h04; c1 = 7'h08; c0 = 7'h10;
    #12;
    check_reset_outputs();

    // Basic scan with a fixed image, plus the frame_start period.
    reset  = 1'b0;
    enable = 1'b1;
    measure_period();
    run(A_LEN);

    // Image change mid-frame shows only after the next snapshot.
    wait_cols(5'b10000, "col4");
    c2 = 7'h55;
    run(2 * A_LEN);

    // Enable dropped mid-frame: frame completes, then idle.
    wait_cols(5'b01000, "col3");
    enable = 1'b0;
    run(2 * A_LEN);
    enable = 1'b1;
    run(A_LEN + 10);

    // Asynchronous reset during column 1 drive.
    wait_cols(5'b00010, "col1");
    reset = 1'b1;
    #1;
    check_reset_outputs();
    pos_a  = -1;
    pos_b  = -1;
    snap_a = '1;
    snap_b = '1;
    @(posedge clock);
    #1;
    check_reset_outputs();
    reset = 1'b0;
    run(A_LEN + 5);

    // Randomized image, enable and blink activity.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) < 3) begin
        case ($urandom_range(0, 4))
          0: c4 = 7'($urandom);
          1: c3 = 7'($urandom);
          2: c2 = 7'($urandom);
          3: c1 = 7'($urandom);
          default: c0 = 7'($urandom);
        endcase
      end
      if ($urandom_range(0, 39) == 0) enable = ~enable;
      blink = 1'($urandom);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
